// File: rtl/vx_ahb_line_subordinate.sv
// AHB-Lite subordinate bridging 32-bit single-beat transfers onto a
// line-wide memory port, with a one-line read buffer.
module vx_ahb_line_subordinate #(
  parameter int MEM_DATA_WIDTH = 512,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic [2:0]                  HSIZE,
  input  logic                        HWRITE,
  input  logic [AHB_DATA_WIDTH-1:0]   HWDATA,
  input  logic                        HREADY,
  output logic                        HREADYOUT,
  output logic                        HRESP,
  output logic [AHB_DATA_WIDTH-1:0]   HRDATA,
  output logic                        mem_req_valid,
  output logic                        mem_req_rw,
  output logic [MEM_DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [MEM_DATA_WIDTH-1:0]   mem_req_data,
  output logic [MEM_TAG_WIDTH-1:0]    mem_req_tag,
  input  logic                        mem_req_ready,
  input  logic                        mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [MEM_TAG_WIDTH-1:0]    mem_rsp_tag,
  output logic                        mem_rsp_ready
);

  localparam int LANES = MEM_DATA_WIDTH / 8;
  localparam int WORDS = MEM_DATA_WIDTH / AHB_DATA_WIDTH;
  localparam int OFFW  = $clog2(LANES);
  localparam int WBW   = $clog2(AHB_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_RESP, S_WR_REQ, S_ERR1, S_ERR2
  } state_t;

  state_t                      state;
  logic [AHB_ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]                  size_q;
  logic                        rd_hit_q;
  logic [MEM_TAG_WIDTH-1:0]    seq;
  logic [MEM_TAG_WIDTH-1:0]    sent_tag;
  logic [MEM_DATA_WIDTH-1:0]   line;
  logic [MEM_ADDR_WIDTH-1:0]   line_tag;
  logic                        line_valid;

  logic                        capture;
  logic                        illegal;
  logic                        done;
  logic                        in_hit;
  logic                        q_hit;
  logic                        rsp_hit;
  logic                        wr_merge;
  logic [MEM_ADDR_WIDTH-1:0]   in_line;
  logic [MEM_ADDR_WIDTH-1:0]   q_line;
  logic [LANES-1:0]            mask;
  logic [LANES-1:0]            wr_byteen;
  logic [MEM_DATA_WIDTH-1:0]   wdata_line;
  logic [OFFW-WBW-1:0]         word_sel;
  logic [AHB_DATA_WIDTH-1:0]   rd_word;

  assign capture = HSEL & HREADY & (HTRANS inside {2'b10, 2'b11});
  assign illegal = (HSIZE >= 3'd3)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
  assign in_line = HADDR[AHB_ADDR_WIDTH-1 -: MEM_ADDR_WIDTH];
  assign q_line  = addr_q[AHB_ADDR_WIDTH-1 -: MEM_ADDR_WIDTH];
  assign in_hit  = line_valid && (line_tag == in_line);
  assign q_hit   = line_valid && (line_tag == q_line);
  assign done    = (state inside {S_IDLE, S_RD_RESP, S_ERR2})
                 | ((state == S_WR_REQ) & mem_req_ready);
  assign rsp_hit = (state == S_RD_WAIT) & mem_rsp_valid
                 & (mem_rsp_tag == sent_tag);
  assign wr_merge = (state == S_WR_REQ) & mem_req_ready & q_hit;

  assign wdata_line = {WORDS{HWDATA}};
  assign word_sel   = addr_q[OFFW-1:WBW];
  assign rd_word    = line[word_sel*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
  assign mem_rsp_ready = ~reset;

  always_comb begin
    mask = '0;
    unique case (size_q)
      3'd0:    mask[0]   = 1'b1;
      3'd1:    mask[1:0] = 2'b11;
      default: mask[3:0] = 4'hF;
    endcase
    wr_byteen = mask << addr_q[OFFW-1:0];
  end

  always_comb begin
    HREADYOUT      = 1'b1;
    HRESP          = 1'b0;
    HRDATA         = '0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    unique case (state)
      S_RD_REQ: begin
        HREADYOUT      = 1'b0;
        mem_req_valid  = 1'b1;
        mem_req_byteen = '1;
        mem_req_addr   = q_line;
        mem_req_tag    = seq;
      end
      S_RD_WAIT: HREADYOUT = 1'b0;
      S_RD_RESP: HRDATA = rd_word;
      S_WR_REQ: begin
        HREADYOUT      = mem_req_ready;
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_byteen = wr_byteen;
        mem_req_addr   = q_line;
        mem_req_data   = wdata_line;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: HRDATA = rd_hit_q ? rd_word : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      rd_hit_q   <= 1'b0;
      seq        <= '0;
      sent_tag   <= '0;
      line_tag   <= '0;
      line_valid <= 1'b0;
    end else begin
      rd_hit_q <= 1'b0;
      unique case (state)
        S_RD_REQ: if (mem_req_ready) begin
          state    <= S_RD_WAIT;
          sent_tag <= seq;
          seq      <= seq + 1'b1;
        end
        S_RD_WAIT: if (rsp_hit) begin
          line_tag   <= q_line;
          line_valid <= 1'b1;
          state      <= S_RD_RESP;
        end
        S_ERR1:  state <= S_ERR2;
        default: ;
      endcase
      // completing data phase may overlap the next address phase
      if (done) begin
        if (capture) begin
          addr_q <= HADDR;
          size_q <= HSIZE;
          if (illegal) begin
            state <= S_ERR1;
          end else if (HWRITE) begin
            state <= S_WR_REQ;
          end else if (in_hit) begin
            state    <= S_IDLE;
            rd_hit_q <= 1'b1;
          end else begin
            state <= S_RD_REQ;
          end
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (rsp_hit) begin
        line <= mem_rsp_data;
      end else if (wr_merge) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_byteen[i]) line[i*8 +: 8] <= wdata_line[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_ahb_line_subordinate.sv
// Scoreboard bench: stimulus queues expected AHB and memory-port results,
// independent monitors pop and compare them as the DUT presents them.
module tb_vx_ahb_line_subordinate;

  logic         clk = 1'b0;
  logic         reset;
  logic         hsel;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic [2:0]   hsize;
  logic         hwrite;
  logic [31:0]  hwdata;
  logic         hreadyout;
  logic         hresp;
  logic [31:0]  hrdata;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [63:0]  mem_req_byteen;
  logic [25:0]  mem_req_addr;
  logic [511:0] mem_req_data;
  logic [7:0]   mem_req_tag;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [511:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         mem_rsp_ready;

  always #5 clk = ~clk;

  vx_ahb_line_subordinate dut (
    .clk(clk), .reset(reset),
    .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hreadyout),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    bit          resp;
    int          waits;
  } ahb_exp_t;

  typedef struct {
    bit          rw;
    logic [25:0] addr;
    logic [63:0] byteen;
    logic [7:0]  tag;
    logic [31:0] wword;
  } mem_exp_t;

  ahb_exp_t ahb_q[$];
  mem_exp_t mem_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_seq = 0;
  bit bad_first = 0;
  bit suppress = 0;
  int late_req = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic exp_ahb(input logic [31:0] rd, input bit c,
                         input bit r, input int w);
    ahb_exp_t e;
    e.rdata = rd; e.chk = c; e.resp = r; e.waits = w;
    ahb_q.push_back(e);
  endtask

  task automatic exp_mem(input bit rw, input logic [25:0] a,
                         input logic [63:0] be, input logic [31:0] ww);
    mem_exp_t e;
    e.rw = rw; e.addr = a; e.byteen = be; e.wword = ww;
    e.tag = rw ? 8'h00 : 8'(exp_seq);
    if (!rw) exp_seq = (exp_seq + 1) % 256;
    mem_q.push_back(e);
  endtask

  task automatic ahb(input logic [31:0] a, input logic [2:0] sz,
                     input logic wr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!hreadyout && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL ahb_stall: hreadyout stuck 0 before %0h", a);
    end
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (ahb_q.size() > 0 || mem_q.size() > 0); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // AHB data-phase monitor
  initial begin
    bit pend = 0;
    bit resp_bad = 0;
    int waits = 0;
    ahb_exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (ahb_q.size() > 0 && hresp !== ahb_q[0].resp) resp_bad = 1;
          if (hreadyout) begin
            pend = 0;
            if (ahb_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL ahb_unexpected: completion at %0t", $time);
            end else begin
              e = ahb_q.pop_front();
              chk("waits", 64'(waits), 64'(e.waits));
              chk("hresp", 64'(hresp), 64'(e.resp));
              chk("hresp_hold", 64'(resp_bad), 64'd0);
              if (e.chk) chk("hrdata", 64'(hrdata), 64'(e.rdata));
            end
          end else begin
            waits++;
            if (waits > 64) begin
              n_cmp++; n_err++;
              $display("FAIL ahb_timeout: waits %0d want <=64", waits);
              pend = 0;
              if (ahb_q.size() > 0) void'(ahb_q.pop_front());
            end
          end
        end
        if (hsel && htrans[1] && hreadyout) begin
          pend = 1; waits = 0; resp_bad = 0;
        end
      end
    end
  end

  // memory request monitor
  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_req_valid && mem_req_ready) begin
        if (mem_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_unexpected: addr %0h rw %0b", mem_req_addr,
                   mem_req_rw);
        end else begin
          e = mem_q.pop_front();
          chk("mem_rw", 64'(mem_req_rw), 64'(e.rw));
          chk("mem_addr", 64'(mem_req_addr), 64'(e.addr));
          chk("mem_byteen", mem_req_byteen, e.byteen);
          if (e.rw) begin
            chk("mem_wdata_lo", 64'(mem_req_data[31:0]), 64'(e.wword));
            chk("mem_wdata_hi", 64'(mem_req_data[511:480]), 64'(e.wword));
          end else begin
            chk("mem_tag", 64'(mem_req_tag), 64'(e.tag));
          end
        end
      end
    end
  end

  // memory model: answers reads one cycle after the handshake
  initial begin
    int late_done = 0;
    logic [7:0] t;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_tag = '0;
    forever begin
      @(negedge clk);
      if (late_req != late_done) begin
        late_done = late_req;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_tag = 8'h00;
        mem_rsp_data = pat(32'hC000_0000);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end else if (!reset && !suppress && mem_req_valid && mem_req_ready
                   && !mem_req_rw) begin
        t = mem_req_tag;
        @(posedge clk); #1;
        if (bad_first) begin
          mem_rsp_valid = 1'b1; mem_rsp_tag = t ^ 8'h05;
          mem_rsp_data = pat(32'hBAD0_0000);
          @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b1; mem_rsp_tag = t;
        mem_rsp_data = pat(32'hA000_0000);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hsize = 3'd0;
    hwrite = 1'b0; hwdata = '0; mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("rst_hresp", 64'(hresp), 64'd0);
    chk("rst_hrdata", 64'(hrdata), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_byteen", mem_req_byteen, 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_req_tag", 64'(mem_req_tag), 64'd0);
    chk("rst_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rsp_ready", 64'(mem_rsp_ready), 64'd1);

    // read miss, then hit in the same line
    exp_mem(0, 26'h41, '1, 0);
    exp_ahb(32'hA000_0001, 1, 0, 2);
    ahb(32'h0000_1044, 3'd2, 0, 0);
    exp_ahb(32'hA000_0002, 1, 0, 0);
    ahb(32'h0000_1048, 3'd2, 0, 0);

    // write hits merge into the buffer
    exp_mem(1, 26'h41, 64'h0F00, 32'hDEAD_BEEF);
    exp_ahb(0, 0, 0, 0);
    ahb(32'h0000_1048, 3'd2, 1, 32'hDEAD_BEEF);
    exp_ahb(32'hDEAD_BEEF, 1, 0, 0);
    ahb(32'h0000_1048, 3'd2, 0, 0);
    exp_mem(1, 26'h41, 64'h0200, 32'h0000_7700);
    exp_ahb(0, 0, 0, 0);
    ahb(32'h0000_1049, 3'd0, 1, 32'h0000_7700);
    exp_ahb(32'hDEAD_77EF, 1, 0, 0);
    ahb(32'h0000_1048, 3'd2, 0, 0);
    drain();

    // byte write miss with memory stalling three cycles
    mem_req_ready = 1'b0;
    exp_mem(1, 26'h80, 64'h8, 32'h5500_0000);
    exp_ahb(0, 0, 0, 3);
    ahb(32'h0000_2003, 3'd0, 1, 32'h5500_0000);
    repeat (3) @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    exp_ahb(32'hDEAD_77EF, 1, 0, 0);
    ahb(32'h0000_1048, 3'd2, 0, 0);

    // illegal size/alignment: two-cycle ERROR, no memory traffic
    exp_ahb(0, 0, 1, 1);
    ahb(32'h0000_1002, 3'd2, 0, 0);
    exp_ahb(0, 0, 1, 1);
    ahb(32'h0000_1000, 3'd3, 0, 0);
    exp_ahb(0, 0, 1, 1);
    ahb(32'h0000_1001, 3'd1, 1, 0);
    exp_ahb(32'hDEAD_77EF, 1, 0, 0);
    ahb(32'h0000_104A, 3'd1, 0, 0);
    drain();

    // stray tag must be dropped before the real response
    bad_first = 1'b1;
    exp_mem(0, 26'hC0, '1, 0);
    exp_ahb(32'hA000_0001, 1, 0, 3);
    ahb(32'h0000_3004, 3'd2, 0, 0);
    drain();
    bad_first = 1'b0;

    // sequence tag wraps through 0xFF -> 0x00
    for (int i = 0; i < 256; i++) begin
      exp_mem(0, 26'h400 + 26'(i), '1, 0);
      exp_ahb(32'hA000_0000 + 32'(i % 16), 1, 0, 2);
      ahb(32'h0001_0000 + 32'(i * 64) + 32'((i % 16) * 4), 3'd2, 0, 0);
    end
    drain();

    // reset in RD_WAIT invalidates the buffer
    exp_mem(0, 26'h140, '1, 0);
    exp_ahb(32'hA000_0000, 1, 0, 2);
    ahb(32'h0000_5000, 3'd2, 0, 0);
    drain();
    suppress = 1'b1;
    exp_mem(0, 26'h180, '1, 0);
    ahb(32'h0000_6000, 3'd2, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_hreadyout", 64'(hreadyout), 64'd1);
    chk("mid_rst_hresp", 64'(hresp), 64'd0);
    chk("mid_rst_hrdata", 64'(hrdata), 64'd0);
    chk("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_seq = 0;
    late_req++;
    repeat (4) @(posedge clk);
    #1;
    suppress = 1'b0;
    exp_mem(0, 26'h140, '1, 0);
    exp_ahb(32'hA000_0001, 1, 0, 2);
    ahb(32'h0000_5004, 3'd2, 0, 0);
    drain();

    chk("ahb_q_left", 64'(ahb_q.size()), 64'd0);
    chk("mem_q_left", 64'(mem_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
